// File: rtl/pong_timer_ctrl.sv
// pong_timer_ctrl: game-state FSM and seconds/ball countdown for the pong
// text overlay. All outputs are registered.
// Optional feature: define PONG_TIMER_BONUS_EN to let a paddle hit add 5 s
// to the countdown, saturating at 99. Without it, `hit` is ignored.
module pong_timer_ctrl #(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned START_SEC = 60,
  parameter int unsigned BALLS     = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       miss,
  input  logic       hit,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [6:0] timer,
  output logic [1:0] ball,
  output logic       run,
  output logic       game_over
);

  localparam int unsigned    PW          = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRESC_MAX   = PW'(CLK_HZ - 1);
  localparam logic [3:0]     START_TENS  = 4'(START_SEC / 10);
  localparam logic [3:0]     START_UNITS = 4'(START_SEC % 10);
  localparam logic [6:0]     START_T     = 7'(START_SEC);
  localparam logic [1:0]     BALLS_R     = 2'(BALLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [PW-1:0]  presc, presc_nx;
  logic [3:0]     dig1_nx, dig0_nx;
  logic [6:0]     timer_nx;
  logic [1:0]     ball_nx;
  logic           tick;
  logic [7:0]     sum;
  logic           hit_en;

`ifdef PONG_TIMER_BONUS_EN
  assign hit_en = hit;
`else
  // port kept for drop-in compatibility; bonus disabled
  assign hit_en = 1'b0 & hit;
`endif

  // binary 0..99 to two BCD digits (used only on the bonus path)
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens = '0;
    for (int unsigned i = 1; i < 10; i++) begin
      if (v >= 7'(10 * i)) tens = 4'(i);
    end
    units = 4'(v - 7'(tens) * 7'd10);
    return {tens, units};
  endfunction

  // next-state and next-counter values; zero results take priority over pause
  always_comb begin
    state_nx = state;
    presc_nx = presc;
    dig1_nx  = dig1;
    dig0_nx  = dig0;
    timer_nx = timer;
    ball_nx  = ball;
    tick     = 1'b0;
    sum      = '0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        tick     = (presc == PRESC_MAX);
        presc_nx = tick ? '0 : presc + 1'b1;
        if (hit_en) begin
          // tick and hit together net +4; digits rebuilt from the binary sum
          sum = {1'b0, timer} + (tick ? 8'd4 : 8'd5);
          if (sum > 8'd99) sum = 8'd99;
          timer_nx           = sum[6:0];
          {dig1_nx, dig0_nx} = to_bcd(sum[6:0]);
        end else if (tick) begin
          timer_nx = timer - 1'b1;
          if (dig0 == 4'd0) begin
            dig0_nx = 4'd9;
            dig1_nx = dig1 - 1'b1;
          end else begin
            dig0_nx = dig0 - 1'b1;
          end
        end
        if (miss) ball_nx = ball - 1'b1;
        if (timer_nx == '0 || ball_nx == '0) state_nx = OVER;
        else if (pause)                      state_nx = PAUSE;
      end
      PAUSE: begin
        if (pause) state_nx = RUN;
      end
      OVER: begin
        if (start) begin
          state_nx = IDLE;
          presc_nx = '0;
          dig1_nx  = START_TENS;
          dig0_nx  = START_UNITS;
          timer_nx = START_T;
          ball_nx  = BALLS_R;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // state, counters and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      presc     <= '0;
      dig1      <= START_TENS;
      dig0      <= START_UNITS;
      timer     <= START_T;
      ball      <= BALLS_R;
      run       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      presc     <= presc_nx;
      dig1      <= dig1_nx;
      dig0      <= dig0_nx;
      timer     <= timer_nx;
      ball      <= ball_nx;
      run       <= (state_nx == RUN);
      game_over <= (state_nx == OVER);
    end
  end

endmodule

// File: tb/tb_pong_timer_ctrl.sv
// Directed bench for pong_timer_ctrl; five instances with different parameters.
module tb_pong_timer_ctrl;

  logic       clk;
  logic       reset_n;
  logic [4:0] start, pause, miss, hit;
  logic [3:0] dig1 [5];
  logic [3:0] dig0 [5];
  logic [6:0] timer [5];
  logic [1:0] ball [5];
  logic [4:0] run, game_over;

  int tests = 0;
  int fails = 0;

`ifdef PONG_TIMER_BONUS_EN
  localparam int HIT_T1 = 99, HIT_T2 = 99, HIT_D0 = 9;
`else
  localparam int HIT_T1 = 97, HIT_T2 = 97, HIT_D0 = 7;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: countdown 11; 1: game over at 2; 2: reset 12 / pause; 3: one ball; 4: bonus
  pong_timer_ctrl #(.CLK_HZ(4), .START_SEC(11), .BALLS(3)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .pause(pause[0]), .miss(miss[0]),
    .hit(hit[0]), .dig1(dig1[0]), .dig0(dig0[0]), .timer(timer[0]), .ball(ball[0]),
    .run(run[0]), .game_over(game_over[0]));
  pong_timer_ctrl #(.CLK_HZ(4), .START_SEC(2), .BALLS(3)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .pause(pause[1]), .miss(miss[1]),
    .hit(hit[1]), .dig1(dig1[1]), .dig0(dig0[1]), .timer(timer[1]), .ball(ball[1]),
    .run(run[1]), .game_over(game_over[1]));
  pong_timer_ctrl #(.CLK_HZ(4), .START_SEC(12), .BALLS(3)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .pause(pause[2]), .miss(miss[2]),
    .hit(hit[2]), .dig1(dig1[2]), .dig0(dig0[2]), .timer(timer[2]), .ball(ball[2]),
    .run(run[2]), .game_over(game_over[2]));
  pong_timer_ctrl #(.CLK_HZ(4), .START_SEC(5), .BALLS(1)) u3 (
    .clk(clk), .reset_n(reset_n), .start(start[3]), .pause(pause[3]), .miss(miss[3]),
    .hit(hit[3]), .dig1(dig1[3]), .dig0(dig0[3]), .timer(timer[3]), .ball(ball[3]),
    .run(run[3]), .game_over(game_over[3]));
  pong_timer_ctrl #(.CLK_HZ(1000), .START_SEC(97), .BALLS(3)) u4 (
    .clk(clk), .reset_n(reset_n), .start(start[4]), .pause(pause[4]), .miss(miss[4]),
    .hit(hit[4]), .dig1(dig1[4]), .dig0(dig0[4]), .timer(timer[4]), .ball(ball[4]),
    .run(run[4]), .game_over(game_over[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int unsigned i);
    start[i] = 1'b1; step(1); start[i] = 1'b0;
  endtask
  task automatic pulse_pause(input int unsigned i);
    pause[i] = 1'b1; step(1); pause[i] = 1'b0;
  endtask
  task automatic pulse_miss(input int unsigned i);
    miss[i] = 1'b1; step(1); miss[i] = 1'b0;
  endtask
  task automatic pulse_hit(input int unsigned i);
    hit[i] = 1'b1; step(1); hit[i] = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start = '0; pause = '0; miss = '0; hit = '0;
    #12 reset_n = 1'b1;
    step(1);

    // reset values, START_SEC=12 BALLS=3
    chk("rst_dig1", 32'(dig1[2]), 1);
    chk("rst_dig0", 32'(dig0[2]), 2);
    chk("rst_timer", 32'(timer[2]), 12);
    chk("rst_ball", 32'(ball[2]), 3);
    chk("rst_run", 32'(run[2]), 0);
    chk("rst_over", 32'(game_over[2]), 0);

    // countdown 11 -> 10 -> 09
    pulse_start(0);
    chk("cd_run", 32'(run[0]), 1);
    chk("cd_timer0", 32'(timer[0]), 11);
    step(3);
    chk("cd_pre_tick", 32'(timer[0]), 11);
    step(1);
    chk("cd_10_timer", 32'(timer[0]), 10);
    chk("cd_10_dig1", 32'(dig1[0]), 1);
    chk("cd_10_dig0", 32'(dig0[0]), 0);
    step(4);
    chk("cd_09_timer", 32'(timer[0]), 9);
    chk("cd_09_dig1", 32'(dig1[0]), 0);
    chk("cd_09_dig0", 32'(dig0[0]), 9);

    // timeout to OVER, freeze, restart to IDLE
    pulse_start(1);
    step(7);
    chk("to_pre_timer", 32'(timer[1]), 1);
    chk("to_pre_over", 32'(game_over[1]), 0);
    step(1);
    chk("to_timer", 32'(timer[1]), 0);
    chk("to_over", 32'(game_over[1]), 1);
    chk("to_run", 32'(run[1]), 0);
    pulse_pause(1);
    step(5);
    chk("to_frozen", 32'(timer[1]), 0);
    chk("to_frozen_over", 32'(game_over[1]), 1);
    pulse_start(1);
    chk("to_idle_timer", 32'(timer[1]), 2);
    chk("to_idle_dig0", 32'(dig0[1]), 2);
    chk("to_idle_over", 32'(game_over[1]), 0);
    chk("to_idle_run", 32'(run[1]), 0);

    // pause preserves prescaler; miss ignored while paused
    pulse_start(2);
    step(1);
    pulse_pause(2);
    chk("pa_run", 32'(run[2]), 0);
    pulse_miss(2);
    step(19);
    chk("pa_ball", 32'(ball[2]), 3);
    chk("pa_timer", 32'(timer[2]), 12);
    pulse_pause(2);
    chk("pa_resume_run", 32'(run[2]), 1);
    step(1);
    chk("pa_resume_hold", 32'(timer[2]), 12);
    step(1);
    chk("pa_tick_timer", 32'(timer[2]), 11);
    chk("pa_tick_dig0", 32'(dig0[2]), 1);
    pulse_miss(2);
    chk("run_miss_ball", 32'(ball[2]), 2);
    chk("run_miss_run", 32'(run[2]), 1);

    // last ball lost on the tick cycle
    pulse_start(3);
    step(3);
    pulse_miss(3);
    chk("mt_ball", 32'(ball[3]), 0);
    chk("mt_timer", 32'(timer[3]), 4);
    chk("mt_dig0", 32'(dig0[3]), 4);
    chk("mt_over", 32'(game_over[3]), 1);
    chk("mt_run", 32'(run[3]), 0);

    // paddle hit bonus (or no effect when the feature is compiled out)
    pulse_start(4);
    pulse_hit(4);
    chk("hit1_timer", 32'(timer[4]), 32'(HIT_T1));
    chk("hit1_dig1", 32'(dig1[4]), 9);
    chk("hit1_dig0", 32'(dig0[4]), 32'(HIT_D0));
    pulse_hit(4);
    chk("hit2_timer", 32'(timer[4]), 32'(HIT_T2));
    chk("hit2_dig0", 32'(dig0[4]), 32'(HIT_D0));

    // asynchronous reset mid-game
    #2 reset_n = 1'b0;
    #1;
    chk("mr_timer", 32'(timer[0]), 11);
    chk("mr_dig1", 32'(dig1[0]), 1);
    chk("mr_run", 32'(run[0]), 0);
    chk("mr_ball", 32'(ball[2]), 3);
    reset_n = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pong_timer_ctrl.md
# pong_timer_ctrl

Game-state and countdown controller for the pong text overlay. It produces the two BCD seconds digits, the binary seconds value and the remaining-ball count that the text overlay renders on its score line. It also produces a game-over flag that the overlay and graphics muxes use to select the "Game Over" region. It sits between the button/collision logic and the text overlay, on the same pixel clock.

## Interface
Parameters:
- `CLK_HZ`, default 25_000_000: clock cycles per game second (prescaler terminal count + 1); legal ≥ 2.
- `START_SEC`, default 60: countdown reload value; legal 1..99.
- `BALLS`, default 3: ball reload value; legal 1..3.

Ports:
- `clk` in 1: pixel/system clock. Single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse. Begins a game from IDLE; returns to IDLE from OVER.
- `pause` in 1: one-cycle pulse. Toggles RUN↔PAUSE; ignored elsewhere.
- `miss` in 1: one-cycle pulse when the ball is lost.
- `hit` in 1: one-cycle pulse on a paddle hit. Used only with the bonus feature.
- `dig1` out 4: BCD tens of remaining seconds.
- `dig0` out 4: BCD units of remaining seconds.
- `timer` out 7: binary remaining seconds; always equals dig1*10+dig0.
- `ball` out 2: remaining balls.
- `run` out 1: high in RUN.
- `game_over` out 1: high in OVER.

## Operation
- States:
  - IDLE: reload values held, prescaler = 0.
  - RUN: prescaler counts; `miss` and `hit` are honoured.
  - PAUSE: all counters frozen; `miss` and `hit` are ignored.
  - OVER: all counters frozen.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --pause--> PAUSE; PAUSE --pause--> RUN. The prescaler value is preserved across the pause.
  - RUN --(seconds reach 0 or ball reaches 0)--> OVER.
  - OVER --start--> IDLE.
  - Any other input in any state: no transition.
- On entry to IDLE (including from reset), outputs load START_SEC (dig1/dig0/timer) and BALLS (ball), and the prescaler clears.
- Prescaler counts 0..CLK_HZ-1 in RUN and wraps to 0. The cycle where it equals CLK_HZ-1 is the one-second tick.
- Tick decrement:
  - dig0 decrements.
  - If dig0 = 0, dig0 becomes 9 and dig1 decrements.
  - timer decrements in parallel.
  - Never underflows: the transition to OVER fires on the tick that makes the value 0.
- `miss` in RUN decrements `ball`. When `ball` becomes 0, go to OVER.
- Simultaneous tick and `miss`: both apply in the same cycle. OVER is taken if either result is 0.
- `start` and `pause` in the same cycle: `start` wins in IDLE/OVER, `pause` wins in RUN/PAUSE.
- Reset mid-game: all state is lost immediately and the block returns to IDLE.

## Timing
- All outputs are registered.
- Reset values: dig1/dig0 = BCD of START_SEC, timer = START_SEC, ball = BALLS, run = 0, game_over = 0, state = IDLE.
- `start` in cycle N: `run` = 1 from cycle N+1.
- First tick: CLK_HZ cycles after entering RUN. Its decrement is visible on the following edge.
- `miss` in cycle N: `ball` updates at N+1. If `ball` becomes 0, `game_over` = 1 and `run` = 0 at N+1.
- `game_over` is asserted in the same cycle that the zero value appears.
- Inputs are assumed synchronous, single-cycle pulses. A pulse held high counts once per cycle.

## Configuration
- `PONG_TIMER_BONUS_EN` defined:
  - `hit` in RUN adds 5 seconds, saturating at 99. Both BCD digits and `timer` are updated consistently.
  - If `hit` coincides with a tick, the net change is +4, again saturating at 99.
- Undefined: `hit` is ignored in all states. The port remains present.

## Test plan
- Reset with START_SEC=12, BALLS=3 → dig1=1, dig0=2, timer=12, ball=3, run=0, game_over=0.
- CLK_HZ=4, START_SEC=11, then `start` → after 4 cycles: 10 (dig1=1, dig0=0). After 4 more: 09 (dig1=0, dig0=9, timer=9).
- CLK_HZ=4, START_SEC=2: `start`, wait 8 cycles → timer=0 and game_over=1 on the same edge. Values then stay frozen. `start` → IDLE with timer=2.
- `pause` 2 cycles after `start`, hold 20 cycles, then `pause` again → the tick occurs 2 cycles later. `miss` during PAUSE leaves ball unchanged.
- BALLS=1: `miss` coincident with a tick → ball=0, timer decremented, game_over=1 at the next edge.
- PONG_TIMER_BONUS_EN, timer=97: `hit` → 99. `hit` again → still 99. Without the macro: `hit` → timer unchanged.
